intf_rx_packer: RTL and testbench

//  Receive (slave) end of the parameterised valid/data interface. Captures IN_WIDTH-bit beats

---
 rtl/intf_rx_packer.sv | 117 +++++++++++
 tb/tb_intf_rx_packer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/intf_rx_packer.sv
// Receive end of the valid/data link: packs RATIO beats per word into a DEPTH-entry FIFO.
// Optional feature: define INTF_RX_OVF_CNT_EN to add the saturating ovf_cnt drop counter.
module intf_rx_packer #(
    parameter int IN_WIDTH = 16,
    parameter int RATIO    = 2,
    parameter int DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [IN_WIDTH-1:0]           in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IN_WIDTH*RATIO-1:0]     out_data,
    output logic [$clog2(DEPTH+1)-1:0]    out_level,
    output logic                          overflow,
`ifdef INTF_RX_OVF_CNT_EN
    output logic [15:0]                   ovf_cnt,
`endif
    input  logic                          clr_ovf
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int PW        = $clog2(DEPTH);
    localparam int LW        = $clog2(DEPTH + 1);

    logic                 word_done;
    logic [OUT_WIDTH-1:0] packed_word;

    generate
        if (RATIO == 1) begin : g_direct
            assign word_done   = in_valid;
            assign packed_word = in_data;
        end else begin : g_pack
            localparam int IW = $clog2(RATIO);
            logic [IW-1:0]       lane_idx;
            logic [IN_WIDTH-1:0] lanes [RATIO-1];

            assign word_done = in_valid && (lane_idx == IW'(RATIO - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_idx <= '0;
                    for (int i = 0; i < RATIO - 1; i++) lanes[i] <= '0;
                end else if (in_valid) begin
                    if (lane_idx == IW'(RATIO - 1)) begin
                        lane_idx <= '0;
                    end else begin
                        for (int i = 0; i < RATIO - 1; i++)
                            if (lane_idx == IW'(i)) lanes[i] <= in_data;
                        lane_idx <= lane_idx + IW'(1);
                    end
                end
            end

            // The completing beat lands in the top lane without being stored.
            always_comb begin
                packed_word = '0;
                packed_word[OUT_WIDTH-1 -: IN_WIDTH] = in_data;
                for (int i = 0; i < RATIO - 1; i++)
                    packed_word[i*IN_WIDTH +: IN_WIDTH] = lanes[i];
            end
        end
    endgenerate

    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [LW-1:0]        count;
    logic                 pop;
    logic                 full;
    logic                 do_write;
    logic                 drop;

    assign out_valid = (count != '0);
    assign out_level = count;
    assign out_data  = mem[rd_ptr];
    assign full      = (count == LW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // When full, a same-edge pop frees the slot the new word is written into.
    assign do_write  = word_done && (!full || pop);
    assign drop      = word_done && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= packed_word;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + LW'(do_write) - LW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        overflow <= 1'b0;
        else if (drop)     overflow <= 1'b1;
        else if (clr_ovf)  overflow <= 1'b0;
    end

`ifdef INTF_RX_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_cnt <= '0;
        else if (clr_ovf)
            ovf_cnt <= drop ? 16'd1 : 16'd0;
        else if (drop && ovf_cnt != 16'hFFFF)
            ovf_cnt <= ovf_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_intf_rx_packer.sv
// Directed self-checking bench for intf_rx_packer at default parameters.
// ovf_cnt checks are compiled in only when INTF_RX_OVF_CNT_EN is defined.
module tb_intf_rx_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_level;
    logic        overflow;
    logic        clr_ovf;
`ifdef INTF_RX_OVF_CNT_EN
    logic [15:0] ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    intf_rx_packer #(.IN_WIDTH(16), .RATIO(2), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_level (out_level),
        .overflow  (overflow),
`ifdef INTF_RX_OVF_CNT_EN
        .ovf_cnt   (ovf_cnt),
`endif
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of beat inputs; returns 1 time unit after the rising edge.
    task automatic applyStimulus(input logic v, input logic [15:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_data", 64'(out_data), 64'd0);
        checkOutput("rst_level", 64'(out_level), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;

        // T1: two back-to-back beats, consumer ready
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h1111);
        checkOutput("t1_valid_mid", 64'(out_valid), 64'd0);
        checkOutput("t1_level_mid", 64'(out_level), 64'd0);
        applyStimulus(1'b1, 16'h2222);
        checkOutput("t1_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_data", 64'(out_data), 64'h2222_1111);
        checkOutput("t1_level", 64'(out_level), 64'd1);
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t1_valid_after", 64'(out_valid), 64'd0);
        checkOutput("t1_level_after", 64'(out_level), 64'd0);

        // T2: gap between the two halves of a word
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'hAAAA);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 16'hFFFF);
            checkOutput("t2_gap_valid", 64'(out_valid), 64'd0);
        end
        applyStimulus(1'b1, 16'hBBBB);
        checkOutput("t2_data", 64'(out_data), 64'hBBBB_AAAA);
        checkOutput("t2_level", 64'(out_level), 64'd1);
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t2_hold", 64'(out_data), 64'hBBBB_AAAA);
        out_ready = 1'b1;
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t2_level_after", 64'(out_level), 64'd0);

        // T3: overflow while consumer stalled, sticky flag and clear behaviour
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(i));
        checkOutput("t3_level_full", 64'(out_level), 64'd4);
        checkOutput("t3_ovf_at_full", 64'(overflow), 64'd0);
        applyStimulus(1'b1, 16'd9);
        applyStimulus(1'b1, 16'd10);
        checkOutput("t3_level", 64'(out_level), 64'd4);
        checkOutput("t3_ovf", 64'(overflow), 64'd1);
        for (int i = 11; i <= 14; i++) applyStimulus(1'b1, 16'(i));
        checkOutput("t3_ovf_sticky", 64'(overflow), 64'd1);
`ifdef INTF_RX_OVF_CNT_EN
        checkOutput("t6_cnt3", 64'(ovf_cnt), 64'd3);
`endif
        applyStimulus(1'b1, 16'd15);
        clr_ovf = 1'b1;
        applyStimulus(1'b1, 16'd16);
        checkOutput("t3_clr_set_wins", 64'(overflow), 64'd1);
`ifdef INTF_RX_OVF_CNT_EN
        checkOutput("t6_cnt_clr_drop", 64'(ovf_cnt), 64'd1);
`endif
        applyStimulus(1'b0, 16'h0000);
        clr_ovf = 1'b0;
        checkOutput("t3_clr", 64'(overflow), 64'd0);
`ifdef INTF_RX_OVF_CNT_EN
        checkOutput("t6_cnt_clr", 64'(ovf_cnt), 64'd0);
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("t3_drain_valid", 64'(out_valid), 64'd1);
            checkOutput("t3_drain_data", 64'(out_data),
                        {32'd0, 16'(2 * k + 2), 16'(2 * k + 1)});
            applyStimulus(1'b0, 16'h0000);
        end
        checkOutput("t3_empty", 64'(out_level), 64'd0);

        // T4: word completes on a full FIFO in the same cycle as a pop
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 16'h0100 + 16'(i));
        checkOutput("t4_level_full", 64'(out_level), 64'd4);
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h010A);
        checkOutput("t4_ovf", 64'(overflow), 64'd0);
        checkOutput("t4_level", 64'(out_level), 64'd4);
        for (int k = 1; k < 5; k++) begin
            checkOutput("t4_drain_data", 64'(out_data),
                        {32'd0, 16'h0100 + 16'(2 * k + 2), 16'h0100 + 16'(2 * k + 1)});
            applyStimulus(1'b0, 16'h0000);
        end
        checkOutput("t4_empty", 64'(out_level), 64'd0);

        // T5: reset in the middle of a word and with a word queued
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h1234);
        applyStimulus(1'b1, 16'h5678);
        applyStimulus(1'b1, 16'h5555);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("t5_rst_level", 64'(out_level), 64'd0);
        checkOutput("t5_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("t5_rst_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h6666);
        checkOutput("t5_valid_mid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 16'h7777);
        checkOutput("t5_data", 64'(out_data), 64'h7777_6666);
        checkOutput("t5_level", 64'(out_level), 64'd1);
        out_ready = 1'b1;
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t5_empty", 64'(out_level), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
